mem_access_stage: RTL and testbench

EX/MEM pipeline register plus memory-access stage for the five-stage LEGv8 pipeline. It sits directly downstream of the execute stage and consumes its ALU result, zero flag and branch-target sum. It resolves conditional branches back to fetch and drives a variable-latency data-memory request/acknowledge handshake, stalling upstream stages while an access is outstanding. Results are forwarded into the MEM/WB register for write-back.

---
 rtl/mem_access_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   EX/MEM pipeline register plus memory-access stage of the five-stage LEGv8
//   pipeline. Captures the execute-stage result, resolves conditional
//   branches back to fetch, runs a variable-latency data-memory req/ack
//   handshake (stalling upstream while an access is outstanding) and
//   forwards retired entries into the MEM/WB register.
//
// Optional feature macro: ALIGN_CHECK_EN
//   Defined   : memory ops with address[2:0] != 0 issue no request, retire
//               on the next edge with wb_RegWrite forced low, and pulse
//               align_fault alongside wb_valid. The align_fault port exists
//               only in this build.
//   Undefined : no alignment check; the address passes through unmodified.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid, ALUResult,       execute-stage instruction and its results /
//   AddResult, zero,           control bits, captured when ex_valid=1 and
//   ReadData2, WriteReg,       stall=0
//   Branch, MemRead, MemWrite,
//   RegWrite, MemtoReg
//   stall                      EX/MEM cannot accept; upstream holds inputs
//   PCSrc, BranchTarget        taken-branch redirect to fetch
//   dmem_req, dmem_we,         data-memory request (held stable until ack)
//   dmem_addr, dmem_wdata
//   dmem_rdata, dmem_ack       data-memory response
//   wb_valid, wb_RegWrite,     MEM/WB register outputs
//   wb_MemtoReg, wb_ReadData,
//   wb_ALUResult, wb_WriteReg
//   align_fault                misaligned access (ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] AddResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [DATA_W-1:0] wb_ReadData,
  output logic [DATA_W-1:0] wb_ALUResult,
  output logic [REG_W-1:0]  wb_WriteReg
`ifdef ALIGN_CHECK_EN
  ,
  output logic              align_fault
`endif
);

  typedef enum logic {IDLE, ACCESS} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] add;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  wreg;
    logic              zero;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
  } exmem_t;

  state_e            state_q, state_d;
  exmem_t            m_q, m_d;
  logic              m_valid_q, m_valid_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_memtoreg_q, wb_memtoreg_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [REG_W-1:0]  wb_wreg_q, wb_wreg_d;
  logic              fault_q, fault_d;

  logic load_en;     // EX/MEM captures the incoming instruction this edge
  logic in_access;   // incoming instruction needs a real memory access
  logic m_fault;     // held entry is a misaligned memory op
  logic retire;      // held entry moves into MEM/WB this edge
  logic m_is_load;

`ifdef ALIGN_CHECK_EN
  assign in_access = (MemRead | MemWrite) & (ALUResult[2:0] == 3'b000);
  assign m_fault   = (m_q.memread | m_q.memwrite) & (m_q.alu[2:0] != 3'b000);
  assign align_fault = fault_q;
`else
  assign in_access = MemRead | MemWrite;
  assign m_fault   = 1'b0;
`endif

  assign stall     = (state_q == ACCESS) & ~dmem_ack;
  assign load_en   = ex_valid & ~stall;
  // Both MemRead and MemWrite set is treated as a store.
  assign m_is_load = m_q.memread & ~m_q.memwrite;

  // In IDLE a valid entry is never an outstanding access: aligned memory ops
  // move to ACCESS on the edge they load, so only ALU ops, branches and
  // faulted accesses can sit here. An ack seen in IDLE is ignored.
  assign retire = ((state_q == IDLE) & m_valid_q &
                   (~(m_q.memread | m_q.memwrite) | m_fault)) |
                  ((state_q == ACCESS) & dmem_ack);

  // NOTE: every always_comb variable gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (load_en && in_access) state_d = ACCESS;
      ACCESS: if (dmem_ack) state_d = (load_en && in_access) ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    if (!stall) begin
      m_valid_d = ex_valid;
      if (ex_valid) begin
        m_d.alu      = ALUResult;
        m_d.add      = AddResult;
        m_d.rd2      = ReadData2;
        m_d.wreg     = WriteReg;
        m_d.zero     = zero;
        m_d.branch   = Branch;
        m_d.memread  = MemRead;
        m_d.memwrite = MemWrite;
        m_d.regwrite = RegWrite;
        m_d.memtoreg = MemtoReg;
      end
    end
  end

  always_comb begin
    wb_valid_d    = retire;
    wb_regwrite_d = wb_regwrite_q;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_rdata_d    = wb_rdata_q;
    wb_alu_d      = wb_alu_q;
    wb_wreg_d     = wb_wreg_q;
    fault_d       = 1'b0;
    if (retire) begin
      wb_regwrite_d = m_q.regwrite & ~m_fault;
      wb_memtoreg_d = m_q.memtoreg;
      wb_alu_d      = m_q.alu;
      wb_wreg_d     = m_q.wreg;
      fault_d       = m_fault;
      // Stores and non-memory ops leave the last load data in place.
      if ((state_q == ACCESS) && m_is_load) wb_rdata_d = dmem_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      m_q           <= '0;
      m_valid_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_rdata_q    <= '0;
      wb_alu_q      <= '0;
      wb_wreg_q     <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      m_valid_q     <= m_valid_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_alu_q      <= wb_alu_d;
      wb_wreg_q     <= wb_wreg_d;
      fault_q       <= fault_d;
    end
  end

  // Branches never enter ACCESS, so a taken branch holds EX/MEM for exactly
  // one cycle and PCSrc pulses once.
  assign PCSrc        = m_valid_q & m_q.branch & m_q.zero;
  assign BranchTarget = m_q.add;

  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & m_q.memwrite;
  assign dmem_addr  = dmem_req ? m_q.alu : '0;
  assign dmem_wdata = dmem_req ? m_q.rd2 : '0;

  assign wb_valid     = wb_valid_q;
  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_MemtoReg  = wb_memtoreg_q;
  assign wb_ReadData  = wb_rdata_q;
  assign wb_ALUResult = wb_alu_q;
  assign wb_WriteReg  = wb_wreg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage: directed scenarios followed by
//   a randomized instruction stream with a randomized-latency memory
//   responder, checked against an in-order transaction model (queues of
//   expected retirements and memory requests).
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [DW-1:0] ALUResult, AddResult, ReadData2;
  logic          zero;
  logic [RW-1:0] WriteReg;
  logic          Branch, MemRead, MemWrite, RegWrite, MemtoReg;
  logic          stall, PCSrc;
  logic [DW-1:0] BranchTarget;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [DW-1:0] wb_ReadData, wb_ALUResult;
  logic [RW-1:0] wb_WriteReg;
`ifdef ALIGN_CHECK_EN
  logic          align_fault;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .ALUResult(ALUResult), .AddResult(AddResult), .zero(zero),
    .ReadData2(ReadData2), .WriteReg(WriteReg),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .stall(stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_ReadData(wb_ReadData), .wb_ALUResult(wb_ALUResult),
    .wb_WriteReg(wb_WriteReg)
`ifdef ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ALUResult = '0; AddResult = '0; ReadData2 = '0; zero = 0;
    WriteReg = '0; Branch = 0; MemRead = 0; MemWrite = 0; RegWrite = 0;
    MemtoReg = 0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic set_instr(input logic [DW-1:0] alu, input logic [DW-1:0] add,
                           input logic [DW-1:0] rd2, input logic [RW-1:0] wr,
                           input logic br, input logic z, input logic mr,
                           input logic mw, input logic rw, input logic m2r);
    ex_valid = 1; ALUResult = alu; AddResult = add; ReadData2 = rd2;
    WriteReg = wr; Branch = br; zero = z; MemRead = mr; MemWrite = mw;
    RegWrite = rw; MemtoReg = m2r;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    logic [DW*6+RW+8:0] outs;
    clear_inputs();
    reset = 1;
    tick(); tick();
    outs = {stall, PCSrc, BranchTarget, dmem_req, dmem_we, dmem_addr, dmem_wdata,
            wb_valid, wb_RegWrite, wb_MemtoReg, wb_ReadData, wb_ALUResult, wb_WriteReg};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", outs); end
    reset = 0;
    // Reset in the middle of an outstanding load, ack arriving afterwards.
    set_instr(64'h300, '0, '0, 5'd9, 0, 0, 1, 0, 1, 1);
    tick();
    ex_valid = 0;
    #1;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL reset_pre_req got=%0b want=1", dmem_req); end
    reset = 1;
    tick();
    reset = 0; dmem_ack = 1; dmem_rdata = 64'hBAD;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req_drop got=%0b want=0", dmem_req); end
    outs = {stall, PCSrc, BranchTarget, dmem_req, dmem_we, dmem_addr, dmem_wdata,
            wb_valid, wb_RegWrite, wb_MemtoReg, wb_ReadData, wb_ALUResult, wb_WriteReg};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%0h want=0", outs); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_late_ack got=%0b want=0", wb_valid); end
    dmem_ack = 0;
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_late_ack2 got=%0b want=0", wb_valid); end
  endtask

  task automatic test_alu_op();
    int stalls = 0;
    clear_inputs();
    set_instr(64'h2A, '0, '0, 5'd3, 0, 0, 0, 0, 1, 0);
    #1; stalls += int'(stall);
    tick();
    ex_valid = 0;
    #1; stalls += int'(stall);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_early got=%0b want=0", wb_valid); end
    tick();
    stalls += int'(stall);
    total++; if ({wb_valid, wb_RegWrite, wb_ALUResult, wb_WriteReg} !== {1'b1, 1'b1, 64'h2A, 5'd3})
      begin bad++; $display("FAIL alu_wb got=%0b/%0b/%0h/%0d want=1/1/2a/3",
                            wb_valid, wb_RegWrite, wb_ALUResult, wb_WriteReg); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_pulse got=%0b want=0", wb_valid); end
    total++; if (stalls != 0) begin bad++; $display("FAIL alu_stall got=%0d want=0", stalls); end
  endtask

  task automatic test_load_latency();
    int stalls = 0;
    clear_inputs();
    set_instr(64'h100, '0, 64'h77, 5'd5, 0, 0, 1, 0, 1, 1);
    tick();
    ex_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      dmem_ack   = (c == 3);
      dmem_rdata = (c == 3) ? 64'hDEAD : 64'hFFFF_0000;
      #1;
      total++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 64'h100})
        begin bad++; $display("FAIL load_req c=%0d got=%0b/%0b/%0h want=1/0/100",
                              c, dmem_req, dmem_we, dmem_addr); end
      stalls += int'(stall);
      tick();
    end
    dmem_ack = 0;
    total++; if (stalls != 2) begin bad++; $display("FAIL load_stall_cycles got=%0d want=2", stalls); end
    total++; if ({wb_valid, wb_MemtoReg, wb_ReadData, wb_WriteReg} !== {1'b1, 1'b1, 64'hDEAD, 5'd5})
      begin bad++; $display("FAIL load_wb got=%0b/%0b/%0h/%0d want=1/1/dead/5",
                            wb_valid, wb_MemtoReg, wb_ReadData, wb_WriteReg); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%0b want=0", dmem_req); end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    clear_inputs();
    set_instr(64'h200, '0, 64'h55, 5'd0, 0, 0, 0, 1, 0, 0);
    tick();
    set_instr(64'h208, '0, '0, 5'd7, 0, 0, 1, 0, 1, 1);
    dmem_ack = 1; dmem_rdata = 64'hAAAA;
    #1;
    stalls += int'(stall);
    total++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 64'h200, 64'h55})
      begin bad++; $display("FAIL b2b_store_req got=%0b/%0b/%0h/%0h want=1/1/200/55",
                            dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    tick();
    ex_valid = 0; dmem_ack = 1; dmem_rdata = 64'h1234;
    #1;
    stalls += int'(stall);
    total++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 64'h208})
      begin bad++; $display("FAIL b2b_load_req got=%0b/%0b/%0h want=1/0/208",
                            dmem_req, dmem_we, dmem_addr); end
    total++; if ({wb_valid, wb_RegWrite, wb_ReadData} !== {1'b1, 1'b0, 64'hDEAD})
      begin bad++; $display("FAIL b2b_store_wb got=%0b/%0b/%0h want=1/0/dead",
                            wb_valid, wb_RegWrite, wb_ReadData); end
    tick();
    dmem_ack = 0;
    #1;
    total++; if ({wb_valid, wb_ReadData, wb_WriteReg, dmem_req} !== {1'b1, 64'h1234, 5'd7, 1'b0})
      begin bad++; $display("FAIL b2b_load_wb got=%0b/%0h/%0d/%0b want=1/1234/7/0",
                            wb_valid, wb_ReadData, wb_WriteReg, dmem_req); end
    total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stalls); end
  endtask

  task automatic test_branch();
    clear_inputs();
    set_instr('0, 64'h400, '0, 5'd0, 1, 1, 0, 0, 0, 0);
    #1;
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL br_early got=%0b want=0", PCSrc); end
    tick();
    ex_valid = 0;
    #1;
    total++; if ({PCSrc, BranchTarget} !== {1'b1, 64'h400})
      begin bad++; $display("FAIL br_taken got=%0b/%0h want=1/400", PCSrc, BranchTarget); end
    tick();
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL br_pulse got=%0b want=0", PCSrc); end
    set_instr('0, 64'h800, '0, 5'd0, 1, 0, 0, 0, 0, 0);
    tick();
    ex_valid = 0;
    #1;
    total++; if ({PCSrc, BranchTarget} !== {1'b0, 64'h800})
      begin bad++; $display("FAIL br_not_taken got=%0b/%0h want=0/800", PCSrc, BranchTarget); end
    tick();
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align();
    clear_inputs();
    set_instr(64'h104, '0, '0, 5'd4, 0, 0, 1, 0, 1, 1);
    tick();
    ex_valid = 0;
    #1;
    total++; if ({dmem_req, stall} !== 2'b00)
      begin bad++; $display("FAIL align_no_req got=%0b/%0b want=0/0", dmem_req, stall); end
    tick();
    total++; if ({wb_valid, align_fault, wb_RegWrite} !== 3'b110)
      begin bad++; $display("FAIL align_retire got=%0b/%0b/%0b want=1/1/0",
                            wb_valid, align_fault, wb_RegWrite); end
    tick();
    total++; if (align_fault !== 1'b0) begin bad++; $display("FAIL align_pulse got=%0b want=0", align_fault); end
  endtask
`endif

  // ---------------- randomized test with transaction model ----------------
  typedef struct {
    logic [DW-1:0] alu, add, rd2, rdata;
    logic [RW-1:0] wr;
    logic br, z, mr, mw, rw, m2r;
    int   lat;
  } instr_t;

  typedef struct {
    logic [DW-1:0] alu, rdata;
    logic [RW-1:0] wr;
    logic rw, m2r;
  } wb_exp_t;

  typedef struct {
    logic [DW-1:0] addr, wdata, rdata;
    logic we;
    int   lat;
  } mem_exp_t;

  wb_exp_t       wb_q[$];
  mem_exp_t      mem_q[$];
  instr_t        cur;
  logic [DW-1:0] last_load;
  int            exp_taken, seen_taken, age;
  bit            prev_valid, prev_stall;

  function automatic instr_t rand_instr();
    instr_t t;
    int kind = $urandom_range(0, 4);  // 0 alu, 1 load, 2 store, 3 branch, 4 read+write
    t.alu   = {$urandom, $urandom};
    t.add   = {$urandom, $urandom};
    t.rd2   = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.wr    = RW'($urandom);
    t.z     = 1'($urandom);
    t.lat   = $urandom_range(1, 4);
    t.br = 0; t.mr = 0; t.mw = 0; t.rw = 0; t.m2r = 0;
    case (kind)
      0: t.rw = 1'($urandom);
      1: begin t.mr = 1; t.rw = 1; t.m2r = 1; end
      2: t.mw = 1;
      3: t.br = 1;
      default: begin t.mr = 1; t.mw = 1; end
    endcase
    if (t.mr || t.mw) t.alu[2:0] = 3'b000;
    return t;
  endfunction

  task automatic accept_into_model(input instr_t t);
    wb_exp_t  w;
    mem_exp_t m;
    if (t.mr && !t.mw) last_load = t.rdata;
    w.alu = t.alu; w.rdata = last_load; w.wr = t.wr; w.rw = t.rw; w.m2r = t.m2r;
    wb_q.push_back(w);
    if (t.mr || t.mw) begin
      m.addr = t.alu; m.wdata = t.rd2; m.rdata = t.rdata; m.we = t.mw; m.lat = t.lat;
      mem_q.push_back(m);
    end
    if (t.br && t.z) exp_taken++;
  endtask

  task automatic rand_cycle(input bit draining);
    wb_exp_t e;
    // Retirement check against the in-order expectation queue.
    if (wb_valid === 1'b1) begin
      total++;
      if (wb_q.size() == 0) begin
        bad++; $display("FAIL rnd_wb_extra got=retirement want=none");
      end else begin
        e = wb_q.pop_front();
        if ({wb_ALUResult, wb_ReadData, wb_WriteReg, wb_RegWrite, wb_MemtoReg} !==
            {e.alu, e.rdata, e.wr, e.rw, e.m2r}) begin
          bad++;
          $display("FAIL rnd_wb got=%0h/%0h/%0d/%0b/%0b want=%0h/%0h/%0d/%0b/%0b",
                   wb_ALUResult, wb_ReadData, wb_WriteReg, wb_RegWrite, wb_MemtoReg,
                   e.alu, e.rdata, e.wr, e.rw, e.m2r);
        end
      end
    end
    if (PCSrc === 1'b1) seen_taken++;
    if (prev_valid && !prev_stall) accept_into_model(cur);
    // New instruction unless upstream must hold the stalled one.
    if (!(prev_valid && prev_stall)) begin
      if (draining || $urandom_range(0, 4) == 0) ex_valid = 0;
      else begin
        cur = rand_instr();
        set_instr(cur.alu, cur.add, cur.rd2, cur.wr, cur.br, cur.z, cur.mr, cur.mw, cur.rw, cur.m2r);
      end
    end
    // Memory responder with per-request latency.
    if (dmem_req === 1'b1) begin
      total++;
      if (mem_q.size() == 0) begin
        bad++; $display("FAIL rnd_req_extra got=request want=none");
        dmem_ack = 1; age = 0;
      end else begin
        if ({dmem_addr, dmem_we, dmem_wdata} !== {mem_q[0].addr, mem_q[0].we, mem_q[0].wdata}) begin
          bad++;
          $display("FAIL rnd_req got=%0h/%0b/%0h want=%0h/%0b/%0h", dmem_addr, dmem_we, dmem_wdata,
                   mem_q[0].addr, mem_q[0].we, mem_q[0].wdata);
        end
        if (age == mem_q[0].lat - 1) begin
          dmem_ack   = 1;
          dmem_rdata = mem_q[0].we ? {$urandom, $urandom} : mem_q[0].rdata;
          void'(mem_q.pop_front());
          age = 0;
        end else begin
          dmem_ack = 0; dmem_rdata = {$urandom, $urandom}; age++;
        end
      end
    end else begin
      // Stray acks while idle must be ignored.
      dmem_ack = ($urandom_range(0, 3) == 0); dmem_rdata = {$urandom, $urandom}; age = 0;
    end
    #1;
    prev_valid = ex_valid;
    prev_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int guard = 0;
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    wb_q.delete(); mem_q.delete();
    last_load = '0; exp_taken = 0; seen_taken = 0; age = 0;
    prev_valid = 0; prev_stall = 0;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    while ((wb_q.size() != 0 || mem_q.size() != 0 || prev_valid) && guard < 100) begin
      rand_cycle(1'b1);
      guard++;
    end
    rand_cycle(1'b1);
    total++; if (wb_q.size() != 0 || mem_q.size() != 0)
      begin bad++; $display("FAIL rnd_drain got=%0d/%0d pending want=0/0", wb_q.size(), mem_q.size()); end
    total++; if (seen_taken != exp_taken)
      begin bad++; $display("FAIL rnd_pcsrc got=%0d want=%0d", seen_taken, exp_taken); end
    dmem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_latency();
    test_back_to_back();
    test_branch();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
